// File: rtl/memref_bank_hir_if.sv
// memref_bank_hir_if: kernel read/write ports, host port and status of the HIR memory bank.
interface memref_bank_hir_if #(parameter int WIDTH = 32, parameter int ADDR_W = 6);
  logic [ADDR_W-1:0] r_p0_addr_data;
  logic              r_p0_addr_en;
  logic              r_p0_rd_en;
  logic [WIDTH-1:0]  r_p0_rd_data;
  logic              r_p0_rd_valid;
  logic [ADDR_W-1:0] w_p0_addr_data;
  logic              w_p0_addr_en;
  logic              w_p0_wr_en;
  logic [WIDTH-1:0]  w_p0_wr_data;
  logic              host_sel;
  logic [ADDR_W-1:0] host_addr;
  logic              host_wr_en;
  logic [WIDTH-1:0]  host_wr_data;
  logic [WIDTH-1:0]  host_rd_data;
  logic [31:0]       rd_count;
  logic [31:0]       wr_count;
  logic [2:0]        err;
  modport master (
    output r_p0_addr_data, r_p0_addr_en, r_p0_rd_en, w_p0_addr_data, w_p0_addr_en, w_p0_wr_en,
           w_p0_wr_data, host_sel, host_addr, host_wr_en, host_wr_data,
    input  r_p0_rd_data, r_p0_rd_valid, host_rd_data, rd_count, wr_count, err
  );
  modport slave (
    input  r_p0_addr_data, r_p0_addr_en, r_p0_rd_en, w_p0_addr_data, w_p0_addr_en, w_p0_wr_en,
           w_p0_wr_data, host_sel, host_addr, host_wr_en, host_wr_data,
    output r_p0_rd_data, r_p0_rd_valid, host_rd_data, rd_count, wr_count, err
  );
endinterface

// File: rtl/memref_bank_hir.sv
// memref_bank_hir: synthesizable HIR memory responder with one read port, one write port and a host port.
module memref_bank_hir #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 64,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  memref_bank_hir_if.slave bus
);
  logic [WIDTH-1:0]  mem [SIZE];
  logic              rd_acc, wr_acc, rd_ok, wr_ok, host_ok, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [WIDTH-1:0]  m_wdata;
  logic [RD_LAT-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [RD_LAT];
  logic [WIDTH-1:0]  d_d [RD_LAT];
  logic [WIDTH-1:0]  host_rd_data_q, host_rd_data_d;
  logic [31:0]       rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic [2:0]        err_q, err_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(SIZE);
  endfunction

  always_comb begin
    rd_acc  = bus.r_p0_rd_en & ~bus.host_sel;
    wr_acc  = bus.w_p0_wr_en & ~bus.host_sel;
    rd_ok   = in_range(bus.r_p0_addr_data);
    wr_ok   = in_range(bus.w_p0_addr_data);
    host_ok = in_range(bus.host_addr);
    m_we    = bus.host_sel ? bus.host_wr_en & host_ok : wr_acc & wr_ok;
    m_addr  = bus.host_sel ? bus.host_addr : bus.w_p0_addr_data;
    m_wdata = bus.host_sel ? bus.host_wr_data : bus.w_p0_wr_data;
    // stage 0 samples the array at the accepting edge; every stage holds when no data arrives
    v_d[0] = rd_acc;
    d_d[0] = rd_acc ? (rd_ok ? mem[bus.r_p0_addr_data] : '0) : d_q[0];
    for (int i = 1; i < RD_LAT; i++) begin
      v_d[i] = v_q[i-1];
      d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
    end
    host_rd_data_d = bus.host_sel ? (host_ok ? mem[bus.host_addr] : '0) : host_rd_data_q;
    rd_count_d = rd_count_q + 32'(rd_acc && rd_count_q != '1);
    wr_count_d = wr_count_q + 32'(wr_acc && wr_count_q != '1);
    err_d = err_q | {bus.host_sel & (bus.r_p0_rd_en | bus.w_p0_wr_en),
                     (rd_acc & ~rd_ok) | (wr_acc & ~wr_ok),
                     (rd_acc & ~bus.r_p0_addr_en) | (wr_acc & ~bus.w_p0_addr_en)};
  end

  always_ff @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q            <= '0;
      host_rd_data_q <= '0;
      rd_count_q     <= '0;
      wr_count_q     <= '0;
      err_q          <= '0;
      for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
    end else begin
      v_q            <= v_d;
      host_rd_data_q <= host_rd_data_d;
      rd_count_q     <= rd_count_d;
      wr_count_q     <= wr_count_d;
      err_q          <= err_d;
      for (int i = 0; i < RD_LAT; i++) d_q[i] <= d_d[i];
    end
  end

  assign bus.r_p0_rd_data  = d_q[RD_LAT-1];
  assign bus.r_p0_rd_valid = v_q[RD_LAT-1];
  assign bus.host_rd_data  = host_rd_data_q;
  assign bus.rd_count      = rd_count_q;
  assign bus.wr_count      = wr_count_q;
  assign bus.err           = err_q;
endmodule
